// File: rtl/comparador_threshold.sv
// Registered unsigned threshold detector; defining COMPARADOR_HOLD_EN adds a
// retriggerable hold counter that stretches each detect to HOLD_CYCLES clocks.
module comparador_threshold #(
  parameter int N           = 8,
  parameter int THRESHOLD   = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] datain,
  output logic         dataout
);

  logic w_hit;

  // A zero threshold is always met; skip the compare so it never elaborates as a constant test.
  if (THRESHOLD == 0) begin : g_th_zero
    assign w_hit = 1'b1;
  end else begin : g_th_cmp
    assign w_hit = (datain >= N'(THRESHOLD));
  end

  if (N < 1 || HOLD_CYCLES < 1) begin : g_bad_params
  end

`ifdef COMPARADOR_HOLD_EN
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (w_hit) begin
      r_cnt <= CNT_W'(HOLD_CYCLES);
      r_out <= 1'b1;
    end else if (r_cnt > CNT_W'(1)) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_out <= 1'b1;
    end else begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end
  end
`else
  logic r_out;

  always_ff @(posedge clk) begin
    if (rst) r_out <= 1'b0;
    else     r_out <= w_hit;
  end
`endif

  assign dataout = r_out;

endmodule

// File: tb/tb_comparador_threshold.sv
// Directed bench for comparador_threshold; three instances cover THRESHOLD = 1, 255 and 0.
module tb_comparador_threshold;

`ifdef COMPARADOR_HOLD_EN
  localparam int H = 4;
`else
  localparam int H = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain;
  logic       q1, q255, q0;
  int         n_run = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  comparador_threshold #(.N(8), .THRESHOLD(1),   .HOLD_CYCLES(4)) u_t1 (
    .clk(clk), .rst(rst), .datain(datain), .dataout(q1));
  comparador_threshold #(.N(8), .THRESHOLD(255), .HOLD_CYCLES(4)) u_t255 (
    .clk(clk), .rst(rst), .datain(datain), .dataout(q255));
  comparador_threshold #(.N(8), .THRESHOLD(0),   .HOLD_CYCLES(4)) u_t0 (
    .clk(clk), .rst(rst), .datain(datain), .dataout(q0));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] d);
    rst    = r;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] retrig_exp;

  initial begin
    rst = 1'b1;
    datain = 8'd0;

    // reset dominates a hitting input; THRESHOLD=0 hits on the first free edge
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 8'd10);
      chk("rst_t1", q1, 1'b0);
      chk("rst_t255", q255, 1'b0);
      chk("rst_t0", q0, 1'b0);
    end
    tick(1'b0, 8'd0);
    chk("post_rst_t1", q1, 1'b0);
    chk("post_rst_t255", q255, 1'b0);
    chk("post_rst_t0", q0, 1'b1);

    // single hit: high for exactly H cycles, then low
    tick(1'b1, 8'd0);
    tick(1'b0, 8'd10);
    chk("single_t1_edge0", q1, 1'b1);
    chk("single_t255_edge0", q255, 1'b0);
    for (int i = 1; i < 50; i++) begin
      tick(1'b0, 8'd0);
      chk($sformatf("single_t1_edge%0d", i), q1, (i < H));
      chk($sformatf("single_t0_edge%0d", i), q0, 1'b1);
    end

    // boundaries, each from a fresh reset
    tick(1'b1, 8'd0); tick(1'b0, 8'd1);
    chk("bnd1_t1", q1, 1'b1);  chk("bnd1_t255", q255, 1'b0);
    tick(1'b1, 8'd0); tick(1'b0, 8'd0);
    chk("bnd0_t1", q1, 1'b0);  chk("bnd0_t255", q255, 1'b0); chk("bnd0_t0", q0, 1'b1);
    tick(1'b1, 8'd0); tick(1'b0, 8'd255);
    chk("bnd255_t1", q1, 1'b1); chk("bnd255_t255", q255, 1'b1);
    tick(1'b1, 8'd0); tick(1'b0, 8'd254);
    chk("bnd254_t1", q1, 1'b1); chk("bnd254_t255", q255, 1'b0);

    // retrigger: hits at edges 0 and 2; bit i is the expectation after edge i
`ifdef COMPARADOR_HOLD_EN
    retrig_exp = 7'b0111111;
`else
    retrig_exp = 7'b0000101;
`endif
    tick(1'b1, 8'd0);
    for (int e = 0; e < 7; e++) begin
      tick(1'b0, (e == 0 || e == 2) ? 8'd10 : 8'd0);
      chk($sformatf("retrig_edge%0d", e), q1, retrig_exp[e]);
    end

    // reset in the middle of a hold
    tick(1'b1, 8'd0);
    tick(1'b0, 8'd10);
    chk("rsthold_edge0", q1, 1'b1);
    tick(1'b0, 8'd0);
    chk("rsthold_edge1", q1, (H > 1));
    tick(1'b1, 8'd0);
    chk("rsthold_edge2", q1, 1'b0);
    for (int i = 3; i < 8; i++) begin
      tick(1'b0, 8'd0);
      chk($sformatf("rsthold_edge%0d", i), q1, 1'b0);
    end

    // a pulse that lives only between edges is never seen
    tick(1'b1, 8'd0);
    rst = 1'b0;
    datain = 8'd200;
    #3;
    datain = 8'd0;
    @(posedge clk);
    #1;
    chk("glitch_t1", q1, 1'b0);
    chk("glitch_t255", q255, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
